pe_unpool: RTL

Decoder-side unpooling stage for the binary encoder-decoder array. It takes the binarized, max-pooled pixels and per-channel pool indices produced by the encoder PEs, and scatters each bit back to its recorded position inside a POOL_H×POOL_W window. Positions not selected by the index are zero-filled. Input is a pooled-row stream; output is the upsampled stream, row-major, one full-resolution pixel (D channels) per beat. A two-bank row buffer lets the next pooled row load while the current one is emitted.

---
 rtl/pe_unpool_pkg.sv | 18 +
 rtl/unpool_row_buf.sv | 49 ++++
 rtl/pe_unpool.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/pe_unpool_pkg.sv
// Shared types and helpers for the unpooling stage: emitter state encoding and
// the index-width derivation that the encoder PEs also use.
package pe_unpool_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_EMIT
  } emit_state_t;

  // Ceiling log2 with a floor of 1, so that single-entry dimensions still get a bit.
  function automatic int clogb2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/unpool_row_buf.sv
// Two-bank pooled-row buffer: synchronous write port, asynchronous read port and
// one full flag per bank.
module unpool_row_buf #(
  parameter int ENTRY_W = 8,
  parameter int W_P     = 16,
  parameter int AW      = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic               wr_bank,
  input  logic [AW-1:0]      wr_addr,
  input  logic [ENTRY_W-1:0] wr_data,
  input  logic               wr_last,
  input  logic               rd_bank,
  input  logic [AW-1:0]      rd_addr,
  output logic [ENTRY_W-1:0] rd_data,
  input  logic               free_en,
  input  logic               free_bank,
  output logic [1:0]         full
);

  logic [ENTRY_W-1:0] mem [2][W_P];
  logic [1:0]         set_mask;
  logic [1:0]         clr_mask;

  // NOTE: the storage array has no reset; the full flags alone decide whether an
  // entry is meaningful, so stale contents after reset are never read.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_bank][wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_bank][rd_addr];

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (wr_en && wr_last) set_mask[wr_bank] = 1'b1;
    if (free_en)          clr_mask[free_bank] = 1'b1;
  end

  // Fill and free of different banks on one edge both land.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) full <= '0;
    else        full <= (full | set_mask) & ~clr_mask;
  end

endmodule

// File: rtl/pe_unpool.sv
// Decoder-side unpooling: scatters each pooled bit back to its recorded position
// inside a POOL_H x POOL_W window and streams the upsampled rows out, row-major.
module pe_unpool
  import pe_unpool_pkg::*;
#(
  parameter int D      = 512,
  parameter int POOL_H = 2,
  parameter int POOL_W = 2,
  parameter int W_P    = 16,
  localparam int PINDEX_WIDTH = clogb2(POOL_H * POOL_W)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [D-1:0]              in_data,
  input  logic [D*PINDEX_WIDTH-1:0] in_pindex,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [D-1:0]              out_data,
  output logic                      out_eol
);

  localparam int AW      = clogb2(W_P);
  localparam int RW      = clogb2(POOL_H);
  localparam int CW      = clogb2(POOL_W);
  localparam int ENTRY_W = D * (1 + PINDEX_WIDTH);
  localparam logic [AW-1:0] P_LAST = AW'(W_P - 1);
  localparam logic [RW-1:0] R_LAST = RW'(POOL_H - 1);
  localparam logic [CW-1:0] C_LAST = CW'(POOL_W - 1);

  logic [AW-1:0]           wp;
  logic                    wb;
  logic                    rb;
  logic [RW-1:0]           r;
  logic [AW-1:0]           p;
  logic [CW-1:0]           c;
  logic [1:0]              full;
  logic [ENTRY_W-1:0]      entry;
  logic [D-1:0]            beat;
  logic [PINDEX_WIDTH-1:0] pos;
  logic                    wr_en;
  logic                    can_load;
  logic                    last_beat;
  logic                    load;
  logic                    bank_done;
  emit_state_t             state_q, state_d;

  assign in_ready = ~full[wb];
  assign wr_en    = in_valid & in_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      wb <= 1'b0;
    end else if (wr_en) begin
      if (wp == P_LAST) begin
        wp <= '0;
        wb <= ~wb;
      end else begin
        wp <= wp + 1'b1;
      end
    end
  end

  unpool_row_buf #(
    .ENTRY_W(ENTRY_W),
    .W_P    (W_P),
    .AW     (AW)
  ) u_row_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_bank  (wb),
    .wr_addr  (wp),
    .wr_data  ({in_pindex, in_data}),
    .wr_last  (wp == P_LAST),
    .rd_bank  (rb),
    .rd_addr  (p),
    .rd_data  (entry),
    .free_en  (bank_done),
    .free_bank(rb),
    .full     (full)
  );

  // pos is always inside the window, so an out-of-range index never matches.
  assign pos = PINDEX_WIDTH'(int'(r) * POOL_W + int'(c));

  always_comb begin
    beat = '0;
    for (int k = 0; k < D; k++)
      beat[k] = entry[k] & (entry[D + k*PINDEX_WIDTH +: PINDEX_WIDTH] == pos);
  end

  assign can_load  = ~out_valid | out_ready;
  assign last_beat = (r == R_LAST) && (p == P_LAST) && (c == C_LAST);

  // IDLE loads straight away once its bank fills, keeping fill-to-output at one edge.
  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    bank_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (full[rb]) begin
          load    = can_load;
          state_d = ST_EMIT;
        end
      end
      ST_EMIT: load = can_load;
      default: state_d = ST_IDLE;
    endcase
    if (load && last_beat) begin
      bank_done = 1'b1;
      state_d   = full[~rb] ? ST_EMIT : ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r         <= '0;
      p         <= '0;
      c         <= '0;
      rb        <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_eol   <= 1'b0;
    end else begin
      if (load) begin
        out_valid <= 1'b1;
        out_data  <= beat;
        out_eol   <= (p == P_LAST) && (c == C_LAST);
        if (c == C_LAST) begin
          c <= '0;
          if (p == P_LAST) begin
            p <= '0;
            r <= (r == R_LAST) ? '0 : r + 1'b1;
          end else begin
            p <= p + 1'b1;
          end
        end else begin
          c <= c + 1'b1;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (bank_done) rb <= ~rb;
    end
  end

endmodule
